// File: rtl/lvds_tx_sequencer.sv
// rtl/lvds_tx_sequencer.sv - word-slot sequencer feeding I/Q data words to an LVDS serializer.
// Each sample period spends PREP_WORDS slots preparing, then one slot presenting the data word.
module lvds_tx_sequencer #(
  parameter int          PREP_WORDS = 8,
  parameter logic [12:0] CW_LEVEL   = 13'h0FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_word_done,
  input  logic        i_transmit,
  input  logic        i_abort,
  input  logic        i_reg_cw,
  input  logic        i_msg_done,
  input  logic [12:0] i_sample_i,
  input  logic [12:0] i_sample_q,
  output logic        o_gen_enable,
  output logic [31:0] o_tx_data,
  output logic        o_busy,
  output logic        o_msg_end,
  output logic [15:0] o_word_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREPARE  = 2'd1,
    TRANSMIT = 2'd2
  } state_t;

  localparam logic [31:0] TERM_WORD = 32'h8000_4000;
  localparam logic [3:0]  LAST_CNT  = 4'(PREP_WORDS - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        wd_d, tr_d;
  logic        start_pend, start_pend_n;
  logic        abort_pend, abort_pend_n;
  logic        done_l, done_l_n;
  logic        entry, entry_n;
  logic [31:0] tx_data_n;
  logic [15:0] word_count_n;
  logic        msg_end_n;

  logic        word_ev;
  logic        tr_edge;
  logic [12:0] sel_i, sel_q;
  logic [31:0] data_word;
  logic [15:0] count_inc;

  assign word_ev   = i_word_done & ~wd_d;
  assign tr_edge   = i_transmit & ~tr_d;
  assign sel_i     = i_reg_cw ? CW_LEVEL : i_sample_i;
  assign sel_q     = i_reg_cw ? CW_LEVEL : i_sample_q;
  assign data_word = {2'b10, sel_i, 1'b1, 2'b01, sel_q, 1'b0};
  assign count_inc = (o_word_count == 16'hFFFF) ? o_word_count : o_word_count + 16'd1;

  // gen_enable is qualified combinationally so a done flag latched during entry suppresses it
  assign o_gen_enable = entry & ~done_l;
  assign o_busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      wd_d         <= 1'b1;
      tr_d         <= 1'b1;
      start_pend   <= 1'b0;
      abort_pend   <= 1'b0;
      done_l       <= 1'b0;
      entry        <= 1'b0;
      o_tx_data    <= 32'd0;
      o_word_count <= 16'd0;
      o_msg_end    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      wd_d         <= i_word_done;
      tr_d         <= i_transmit;
      start_pend   <= start_pend_n;
      abort_pend   <= abort_pend_n;
      done_l       <= done_l_n;
      entry        <= entry_n;
      o_tx_data    <= tx_data_n;
      o_word_count <= word_count_n;
      o_msg_end    <= msg_end_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    start_pend_n = start_pend;
    abort_pend_n = abort_pend;
    done_l_n     = done_l;
    entry_n      = 1'b0;
    tx_data_n    = o_tx_data;
    word_count_n = o_word_count;
    msg_end_n    = 1'b0;

    case (state)
      IDLE: begin
        done_l_n     = 1'b0;
        abort_pend_n = 1'b0;
        if (word_ev) begin
          tx_data_n = 32'd0;
          if (start_pend) begin
            cnt_n        = 4'd0;
            word_count_n = 16'd0;
            start_pend_n = 1'b0;
            entry_n      = 1'b1;
            state_n      = PREPARE;
          end
        end
      end
      PREPARE: begin
        if (word_ev) begin
          if (abort_pend) begin
            tx_data_n    = TERM_WORD;
            msg_end_n    = 1'b1;
            abort_pend_n = 1'b0;
            state_n      = IDLE;
          end else begin
            cnt_n = cnt + 4'd1;
            if (cnt == LAST_CNT) begin
              tx_data_n    = data_word;
              word_count_n = count_inc;
              state_n      = TRANSMIT;
            end
          end
        end
      end
      TRANSMIT: begin
        if (word_ev) begin
          if (abort_pend || done_l) begin
            tx_data_n    = TERM_WORD;
            msg_end_n    = 1'b1;
            abort_pend_n = 1'b0;
            state_n      = IDLE;
          end else begin
            tx_data_n = 32'd0;
            cnt_n     = 4'd0;
            entry_n   = 1'b1;
            state_n   = PREPARE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && i_msg_done) done_l_n = 1'b1;
    // abort is applied last so it overrides a same-cycle transmit edge
    if (tr_edge) start_pend_n = 1'b1;
    if (i_abort) begin
      start_pend_n = 1'b0;
      if (state != IDLE) abort_pend_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_lvds_tx_sequencer.sv
// tb/tb_lvds_tx_sequencer.sv - scoreboard bench for lvds_tx_sequencer.
module tb_lvds_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        word_done = 1'b0;
  logic        transmit = 1'b0;
  logic        abort = 1'b0;
  logic        reg_cw = 1'b0;
  logic        msg_done = 1'b0;
  logic [12:0] sample_i = 13'd0;
  logic [12:0] sample_q = 13'd0;
  logic        gen_enable;
  logic [31:0] tx_data;
  logic        busy;
  logic        msg_end;
  logic [15:0] word_count;

  lvds_tx_sequencer #(.PREP_WORDS(8), .CW_LEVEL(13'h0FFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_word_done  (word_done),
    .i_transmit   (transmit),
    .i_abort      (abort),
    .i_reg_cw     (reg_cw),
    .i_msg_done   (msg_done),
    .i_sample_i   (sample_i),
    .i_sample_q   (sample_q),
    .o_gen_enable (gen_enable),
    .o_tx_data    (tx_data),
    .o_busy       (busy),
    .o_msg_end    (msg_end),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        msg_end;
    logic [15:0] wc;
  } exp_t;

  localparam logic [31:0] TERM = 32'h8000_4000;
  localparam logic [31:0] W_A  = 32'h8247_7578;  // I=0123 Q=1ABC
  localparam logic [31:0] W_CW = 32'h9FFF_5FFE;  // I=Q=0FFF
  localparam logic [31:0] W_B  = 32'hAAAB_5554;  // I=1555 Q=0AAA

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int gen_pulses = 0;
  int end_pulses = 0;
  int zero_words = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic me, input logic [15:0] wc);
    exp_t e;
    e.data = d;
    e.msg_end = me;
    e.wc = wc;
    exp_q.push_back(e);
  endtask

  task automatic slots(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1 word_done = 1'b1;
      repeat (4) @(posedge clk);
      #1 word_done = 1'b0;
      repeat (3) @(posedge clk);
    end
    #2;
  endtask

  task automatic pulse_transmit();
    @(posedge clk); #1 transmit = 1'b1;
    repeat (2) @(posedge clk);
    #1 transmit = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // monitor: every change of the serializer word to a nonzero value is a load
  initial begin
    exp_t e;
    logic [31:0] prev;
    prev = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gen_enable) gen_pulses++;
        if (msg_end) end_pulses++;
        if (tx_data != prev) begin
          if (tx_data == 32'd0) begin
            zero_words++;
          end else if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %h, want no load", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("word_data", tx_data, e.data);
            check("word_msg_end", {31'd0, msg_end}, {31'd0, e.msg_end});
            check("word_count", {16'd0, word_count}, {16'd0, e.wc});
          end
        end
      end
      prev = tx_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, e0, z0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gen_enable", {31'd0, gen_enable}, 32'd0);
    check("rst_msg_end", {31'd0, msg_end}, 32'd0);
    check("rst_word_count", {16'd0, word_count}, 32'd0);

    // single-sample message
    g0 = gen_pulses; e0 = end_pulses;
    sample_i = 13'h0123; sample_q = 13'h1ABC;
    push(W_A, 1'b0, 16'd1);
    push(TERM, 1'b1, 16'd1);
    pulse_transmit();
    slots(1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_gen_once", gen_pulses - g0, 32'd1);
    slots(2);
    msg_done = 1'b1;
    slots(5);
    check("t1_latency_early", tx_data, 32'd0);
    slots(1);
    check("t1_latency_data", tx_data, W_A);
    slots(3);
    check("t1_gen_total", gen_pulses - g0, 32'd1);
    check("t1_msg_end", end_pulses - e0, 32'd1);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_count", {16'd0, word_count}, 32'd1);
    msg_done = 1'b0;

    // CW mode, three sample periods
    g0 = gen_pulses; e0 = end_pulses; z0 = zero_words;
    reg_cw = 1'b1;
    sample_i = 13'h0123; sample_q = 13'h0456;
    push(W_CW, 1'b0, 16'd1);
    push(W_CW, 1'b0, 16'd2);
    push(W_CW, 1'b0, 16'd3);
    push(TERM, 1'b1, 16'd3);
    pulse_transmit();
    slots(22);
    msg_done = 1'b1;
    slots(8);
    check("t2_gen", gen_pulses - g0, 32'd3);
    check("t2_msg_end", end_pulses - e0, 32'd1);
    check("t2_zero_words", zero_words - z0, 32'd3);
    check("t2_count", {16'd0, word_count}, 32'd3);
    msg_done = 1'b0;
    reg_cw = 1'b0;

    // abort in PREPARE with cnt = 3
    g0 = gen_pulses; e0 = end_pulses;
    push(TERM, 1'b1, 16'd0);
    pulse_transmit();
    slots(4);
    pulse_abort();
    slots(2);
    check("t3_idle", {31'd0, busy}, 32'd0);
    check("t3_msg_end", end_pulses - e0, 32'd1);
    check("t3_gen", gen_pulses - g0, 32'd1);
    check("t3_count", {16'd0, word_count}, 32'd0);

    // transmit edge during the final TRANSMIT slot queues the next message
    g0 = gen_pulses; e0 = end_pulses;
    sample_i = 13'h1555; sample_q = 13'h0AAA;
    push(W_B, 1'b0, 16'd1);
    push(TERM, 1'b1, 16'd1);
    push(W_B, 1'b0, 16'd1);
    push(TERM, 1'b1, 16'd1);
    pulse_transmit();
    slots(3);
    msg_done = 1'b1;
    slots(6);
    pulse_transmit();
    slots(1);
    check("t4_idle_gap", {31'd0, busy}, 32'd0);
    msg_done = 1'b0;
    slots(1);
    check("t4_restart", {31'd0, busy}, 32'd1);
    check("t4_count_restart", {16'd0, word_count}, 32'd0);
    slots(2);
    msg_done = 1'b1;
    slots(8);
    msg_done = 1'b0;
    check("t4_gen", gen_pulses - g0, 32'd2);
    check("t4_msg_end", end_pulses - e0, 32'd2);
    check("t4_idle_end", {31'd0, busy}, 32'd0);

    // abort and transmit edge together in IDLE: abort wins
    e0 = end_pulses;
    @(posedge clk); #1 transmit = 1'b1; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(posedge clk); #1 transmit = 1'b0;
    slots(2);
    check("t5_abort_idle_busy", {31'd0, busy}, 32'd0);
    check("t5_abort_idle_end", end_pulses - e0, 32'd0);

    // reset mid-PREPARE at cnt = 5
    e0 = end_pulses;
    pulse_transmit();
    slots(6);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    pulse_reset();
    check("t6_tx_data", tx_data, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_gen_enable", {31'd0, gen_enable}, 32'd0);
    check("t6_msg_end_now", {31'd0, msg_end}, 32'd0);
    check("t6_count", {16'd0, word_count}, 32'd0);
    slots(10);
    check("t6_msg_end", end_pulses - e0, 32'd0);
    check("t6_still_idle", {31'd0, busy}, 32'd0);

    // levels held high through reset release produce no events
    @(posedge clk); #1 reset = 1'b1; word_done = 1'b1; transmit = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t7_no_start", {31'd0, busy}, 32'd0);
    word_done = 1'b0;
    slots(2);
    check("t7_no_start_later", {31'd0, busy}, 32'd0);
    transmit = 1'b0;
    repeat (2) @(posedge clk);
    pulse_transmit();
    slots(1);
    check("t7_new_edge", {31'd0, busy}, 32'd1);
    pulse_reset();
    check("t7_reset_idle", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
